// File: rtl/param_regfile.sv
// param_regfile: parameter-stream storage with registered scan/random reads,
// append and in-place writes, fill-level tracking and a sticky overflow flag.
module param_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              re_seq_i,
  input  logic              re_ran_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  input  logic              seq_we_i,
  input  logic [DATA_W-1:0] seq_w_data_i,
  input  logic              ran_we_i,
  input  logic [ADDR_W-1:0] ran_w_addr_i,
  input  logic [DATA_W-1:0] ran_w_data_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              overflow_q;

  logic              full;
  logic              append_ok;
  logic              ran_w_ok;
  logic              rd_en;
  logic [ADDR_W:0]   seq_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // Write qualification, read target selection and write-first read data.
  // All validity checks use the count held before this cycle's append.
  always_comb begin
    full      = (count == DEPTH_C);
    append_ok = seq_we_i && !full;
    ran_w_ok  = ran_we_i && ({1'b0, ran_w_addr_i} < count);
    rd_en     = re_ran_i || re_seq_i;
    seq_inc   = {1'b0, rd_ptr} + 1'b1;
    rd_addr   = '0;
    rd_data   = '0;
    if (re_ran_i) begin
      rd_addr = r_addr_i;
    end else if (count != '0) begin
      // wraps past the last valid entry and also recovers a pointer parked beyond count
      rd_addr = (seq_inc >= count) ? '0 : seq_inc[ADDR_W-1:0];
    end
    if ({1'b0, rd_addr} < count) begin
      if (ran_w_ok && (ran_w_addr_i == rd_addr)) begin
        rd_data = ran_w_data_i;
      end else begin
        rd_data = mem[rd_addr[IDX_W-1:0]];
      end
    end
  end

  // Storage array: contents survive reset and clear; append and random write
  // never target the same entry, so both may land in one cycle.
  always_ff @(posedge clk) begin
    if (!rst && !clear_i) begin
      if (append_ok) begin
        mem[count[IDX_W-1:0]] <= seq_w_data_i;
      end
      if (ran_w_ok) begin
        mem[ran_w_addr_i[IDX_W-1:0]] <= ran_w_data_i;
      end
    end
  end

  // Pointers, fill count, overflow flag and registered read outputs.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count      <= '0;
      rd_ptr     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (append_ok) begin
        count <= count + 1'b1;
      end
      if (seq_we_i && full) begin
        overflow_q <= 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_addr;
        addr_q <= rd_addr;
        data_q <= rd_data;
      end
    end
  end

  // Status outputs derive only from registered state.
  always_comb begin
    addr_o     = addr_q;
    data_o     = data_q;
    count_o    = count;
    empty_o    = (count == '0);
    full_o     = full;
    overflow_o = overflow_q;
  end

endmodule

// File: tb/tb_param_regfile.sv
// Scoreboard bench for param_regfile: a 32-bit and an 18-bit instance share
// stimulus; a DEPTH=4 instance exercises full/overflow.
module tb_param_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        re_seq_i = 1'b0;
  logic        re_ran_i = 1'b0;
  logic [11:0] r_addr_i = '0;
  logic        seq_we_i = 1'b0;
  logic [31:0] seq_w_data_i = '0;
  logic        ran_we_i = 1'b0;
  logic [11:0] ran_w_addr_i = '0;
  logic [31:0] ran_w_data_i = '0;

  logic [11:0] addr_o;
  logic [31:0] data_o;
  logic [12:0] count_o;
  logic        empty_o, full_o, overflow_o;

  logic [11:0] n_addr_o;
  logic [17:0] n_data_o;
  logic [12:0] n_count_o;
  logic        n_empty_o, n_full_o, n_overflow_o;

  logic [2:0]  s_addr_o;
  logic [31:0] s_data_o;
  logic [3:0]  s_count_o;
  logic        s_empty_o, s_full_o, s_overflow_o;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    bit          small_chk;
    logic [31:0] sdata;
  } exp_t;
  exp_t q[$];

  logic rd_fire = 1'b0;

  always #5 clk = ~clk;

  param_regfile #(.DATA_W(32), .ADDR_W(12), .DEPTH(4096)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .re_seq_i(re_seq_i), .re_ran_i(re_ran_i),
    .r_addr_i(r_addr_i), .seq_we_i(seq_we_i), .seq_w_data_i(seq_w_data_i),
    .ran_we_i(ran_we_i), .ran_w_addr_i(ran_w_addr_i), .ran_w_data_i(ran_w_data_i),
    .addr_o(addr_o), .data_o(data_o), .count_o(count_o), .empty_o(empty_o),
    .full_o(full_o), .overflow_o(overflow_o)
  );

  param_regfile #(.DATA_W(18), .ADDR_W(12), .DEPTH(4096)) dut18 (
    .clk(clk), .rst(rst), .clear_i(clear_i), .re_seq_i(re_seq_i), .re_ran_i(re_ran_i),
    .r_addr_i(r_addr_i), .seq_we_i(seq_we_i), .seq_w_data_i(seq_w_data_i[17:0]),
    .ran_we_i(ran_we_i), .ran_w_addr_i(ran_w_addr_i), .ran_w_data_i(ran_w_data_i[17:0]),
    .addr_o(n_addr_o), .data_o(n_data_o), .count_o(n_count_o), .empty_o(n_empty_o),
    .full_o(n_full_o), .overflow_o(n_overflow_o)
  );

  param_regfile #(.DATA_W(32), .ADDR_W(3), .DEPTH(4)) dut_small (
    .clk(clk), .rst(rst), .clear_i(clear_i), .re_seq_i(re_seq_i), .re_ran_i(re_ran_i),
    .r_addr_i(r_addr_i[2:0]), .seq_we_i(seq_we_i), .seq_w_data_i(seq_w_data_i),
    .ran_we_i(ran_we_i), .ran_w_addr_i(ran_w_addr_i[2:0]), .ran_w_data_i(ran_w_data_i),
    .addr_o(s_addr_o), .data_o(s_data_o), .count_o(s_count_o), .empty_o(s_empty_o),
    .full_o(s_full_o), .overflow_o(s_overflow_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A read accepted at an edge (not under reset/clear) produces output after it.
  always @(posedge clk) rd_fire <= !rst && !clear_i && (re_seq_i || re_ran_i);

  // Monitor: pops one expectation per completed read and compares all instances.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_fire) begin
        if (q.size() == 0) begin
          chk("unexpected_read", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rd_addr", {20'd0, addr_o}, {20'd0, e.addr});
          chk("rd_data", data_o, e.data);
          chk("rd_addr18", {20'd0, n_addr_o}, {20'd0, e.addr});
          chk("rd_data18", {14'd0, n_data_o}, {14'd0, e.data[17:0]});
          if (e.small_chk) chk("rd_data_small", s_data_o, e.sdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    re_seq_i = 1'b0; re_ran_i = 1'b0; seq_we_i = 1'b0; ran_we_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic push(input logic [11:0] a, input logic [31:0] d, input bit sc, input logic [31:0] sd);
    exp_t e;
    e.addr = a; e.data = d; e.small_chk = sc; e.sdata = sd;
    q.push_back(e);
  endtask

  task automatic append(input logic [31:0] d);
    seq_we_i = 1'b1; seq_w_data_i = d;
    tick();
  endtask

  task automatic rran(input logic [11:0] a, input logic [31:0] d);
    re_ran_i = 1'b1; r_addr_i = a;
    push(a, d, 1'b0, '0);
    tick();
  endtask

  task automatic rseq(input logic [11:0] a, input logic [31:0] d);
    re_seq_i = 1'b1;
    push(a, d, 1'b0, '0);
    tick();
  endtask

  initial begin
    // reset with a read in the same cycle: the read is discarded
    rst = 1'b1; re_seq_i = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_addr", {20'd0, addr_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_count", {19'd0, count_o}, 32'd0);
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);

    // empty scan
    rseq(12'd0, 32'd0);
    chk("empty_scan1", {31'd0, empty_o}, 32'd1);
    rseq(12'd0, 32'd0);
    chk("empty_scan2", {31'd0, empty_o}, 32'd1);

    // append and wrap scan
    append(32'hA0); chk("cnt1", {19'd0, count_o}, 32'd1);
    append(32'hA1); chk("cnt2", {19'd0, count_o}, 32'd2);
    append(32'hA2); chk("cnt3", {19'd0, count_o}, 32'd3);
    chk("not_empty", {31'd0, empty_o}, 32'd0);
    rran(12'd0, 32'hA0);
    rseq(12'd1, 32'hA1);
    rseq(12'd2, 32'hA2);
    rseq(12'd0, 32'hA0);

    // random write with same-cycle read of the same entry: write-first
    ran_we_i = 1'b1; ran_w_addr_i = 12'd1; ran_w_data_i = 32'h55;
    re_ran_i = 1'b1; r_addr_i = 12'd1;
    push(12'd1, 32'h55, 1'b0, '0);
    tick();
    // random write beyond count is ignored
    ran_we_i = 1'b1; ran_w_addr_i = 12'd5; ran_w_data_i = 32'h99;
    tick();
    chk("ranw_oob_cnt", {19'd0, count_o}, 32'd3);
    rran(12'd5, 32'd0);
    rseq(12'd0, 32'hA0);

    // invalid random read then scan
    rran(12'd7, 32'd0);
    rseq(12'd0, 32'hA0);
    rseq(12'd1, 32'h55);

    // clear overrides a same-cycle append and read
    clear_i = 1'b1; seq_we_i = 1'b1; seq_w_data_i = 32'hEE; re_seq_i = 1'b1;
    tick();
    chk("clr_cnt", {19'd0, count_o}, 32'd0);
    chk("clr_addr", {20'd0, addr_o}, 32'd0);
    chk("clr_data", data_o, 32'd0);
    chk("clr_empty", {31'd0, empty_o}, 32'd1);

    // full / overflow on the DEPTH=4 instance
    for (int unsigned i = 0; i < 5; i++) append(32'h10 + i);
    chk("sm_cnt", {28'd0, s_count_o}, 32'd4);
    chk("sm_full", {31'd0, s_full_o}, 32'd1);
    chk("sm_ovf", {31'd0, s_overflow_o}, 32'd1);
    chk("big_cnt", {19'd0, count_o}, 32'd5);
    chk("big_full", {31'd0, full_o}, 32'd0);
    chk("big_ovf", {31'd0, overflow_o}, 32'd0);
    re_ran_i = 1'b1; r_addr_i = 12'd3;
    push(12'd3, 32'h13, 1'b1, 32'h13);
    tick();
    clear_i = 1'b1;
    tick();
    chk("sm_clr_cnt", {28'd0, s_count_o}, 32'd0);
    chk("sm_clr_ovf", {31'd0, s_overflow_o}, 32'd0);
    chk("sm_clr_empty", {31'd0, s_empty_o}, 32'd1);

    // simultaneous append and random write
    append(32'h1);
    append(32'h2);
    seq_we_i = 1'b1; seq_w_data_i = 32'h77;
    ran_we_i = 1'b1; ran_w_addr_i = 12'd0; ran_w_data_i = 32'h11;
    tick();
    chk("sim_cnt", {19'd0, count_o}, 32'd3);
    chk("sim_cnt18", {19'd0, n_count_o}, 32'd3);
    rran(12'd0, 32'h11);
    rran(12'd2, 32'h77);
    rran(12'd1, 32'h2);

    // wide value: the 18-bit instance keeps only the low bits
    append(32'hDEADBEEF);
    re_ran_i = 1'b1; r_addr_i = 12'd3;
    push(12'd3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    tick();

    // sequential wrap with write-first bypass on the target entry
    re_seq_i = 1'b1;
    ran_we_i = 1'b1; ran_w_addr_i = 12'd0; ran_w_data_i = 32'h0003CAFE;
    push(12'd0, 32'h0003CAFE, 1'b0, '0);
    tick();

    tick();
    tick();
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
